// File: rtl/rack_pkg.sv
// Shared constants and mode encodings for the rack-node spike counting blocks.
package rack_pkg;

  localparam int NCH_DEFAULT   = 14;
  localparam int CNT_W_DEFAULT = 32;
  localparam int WIN_W_DEFAULT = 16;

  typedef enum logic {
    MODE_WINDOWED   = 1'b0,
    MODE_CUMULATIVE = 1'b1
  } mode_e;

endpackage

// File: rtl/spike_chan_counter.sv
// One spike channel: rising-edge detect, saturating accumulator with sticky
// saturation flag, and the snapshot/sat_snap registers loaded at each tick.
module spike_chan_counter
  import rack_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic             mode,
  input  logic             spike,
  output logic [CNT_W-1:0] snap,
  output logic             sat_snap
);

  logic             spike_d;
  logic             sat;
  logic [CNT_W-1:0] acc;
  logic             rise;
  logic             at_max;

  assign rise   = spike & ~spike_d;
  assign at_max = &acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d  <= 1'b0;
      acc      <= '0;
      sat      <= 1'b0;
      snap     <= '0;
      sat_snap <= 1'b0;
    end else begin
      // spike_d keeps tracking through clear so a held level is not recounted
      spike_d <= spike;
      if (clear) begin
        acc      <= '0;
        sat      <= 1'b0;
        snap     <= '0;
        sat_snap <= 1'b0;
      end else if (tick) begin
        snap     <= acc;
        sat_snap <= sat;
        if (mode_e'(mode) == MODE_WINDOWED) begin
          // the coincident edge opens the new window
          acc <= {{(CNT_W-1){1'b0}}, rise};
          sat <= 1'b0;
        end else if (rise) begin
          if (at_max) sat <= 1'b1;
          else        acc <= acc + 1'b1;
        end
      end else if (rise) begin
        if (at_max) sat <= 1'b1;
        else        acc <= acc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_counter_array.sv
// NCH-channel spike counter with tick-delimited windows, a tick counter and a
// registered snapshot read mux feeding the host wire-out endpoints.
module spike_counter_array
  import rack_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int WIN_W = WIN_W_DEFAULT,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   spike_in,
  input  logic             tick,
  input  logic             clear,
  input  logic             mode,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             snap_valid,
  output logic [NCH-1:0]   sat_snap,
  output logic [WIN_W-1:0] win_cnt
);

  logic [CNT_W-1:0] snap [NCH];
  logic [CNT_W-1:0] rd_mux;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      spike_chan_counter #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .tick     (tick),
        .mode     (mode),
        .spike    (spike_in[gi]),
        .snap     (snap[gi]),
        .sat_snap (sat_snap[gi])
      );
    end
  endgenerate

  // Out-of-range selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(rd_sel) == i) rd_mux = snap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data    <= '0;
      snap_valid <= 1'b0;
      win_cnt    <= '0;
    end else begin
      rd_data <= rd_mux;
      if (clear) begin
        rd_data    <= '0;
        snap_valid <= 1'b0;
        win_cnt    <= '0;
      end else begin
        snap_valid <= tick;
        if (tick) win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_counter_array.sv
// Directed scoreboard bench: ticks and reads push expectations; a monitor
// checks them when snap_valid pulses or a read result becomes due.
module tb_spike_counter_array;

  localparam int NCH   = 14;
  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   spike_in = '0;
  logic             tick = 1'b0;
  logic             clear = 1'b0;
  logic             mode = 1'b0;
  logic [SEL_W-1:0] rd_sel = '0;
  logic [CNT_W-1:0] rd_data;
  logic             snap_valid;
  logic [NCH-1:0]   sat_snap;
  logic [WIN_W-1:0] win_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic                   rd_chk = 1'b0;
  logic                   pend;
  logic [WIN_W+NCH-1:0]   snap_e;
  int                     rd_e;
  logic [WIN_W+NCH-1:0]   snap_q [$];
  int                     rd_q   [$];

  always #5 clk = ~clk;

  spike_counter_array #(
    .NCH   (NCH),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .tick       (tick),
    .clear      (clear),
    .mode       (mode),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .snap_valid (snap_valid),
    .sat_snap   (sat_snap),
    .win_cnt    (win_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: snapshot expectations on snap_valid, read results one cycle after rd_sel.
  initial begin
    forever begin
      @(posedge clk);
      pend = rd_chk;
      #1;
      if (snap_valid) begin
        if (snap_q.size() == 0) begin
          chk("unexpected_snap_valid", 1, 0);
        end else begin
          snap_e = snap_q.pop_front();
          chk("snap_win_cnt", win_cnt, snap_e[WIN_W+NCH-1:NCH]);
          chk("snap_sat_snap", sat_snap, snap_e[NCH-1:0]);
        end
      end
      if (pend) begin
        rd_e = rd_q.pop_front();
        chk("rd_data", rd_data, rd_e);
      end
    end
  end

  task automatic pulses(input int ch, input int n);
    repeat (n) begin
      @(negedge clk); spike_in[ch] = 1'b1;
      @(negedge clk); spike_in[ch] = 1'b0;
    end
  endtask

  task automatic do_tick(input int ew, input logic [NCH-1:0] es, input logic [NCH-1:0] coincide);
    @(negedge clk);
    tick = 1'b1;
    spike_in = spike_in | coincide;
    snap_q.push_back({WIN_W'(ew), es});
    @(negedge clk);
    tick = 1'b0;
    spike_in = spike_in & ~coincide;
  endtask

  task automatic rd(input int sel, input int exp);
    @(negedge clk);
    rd_sel = SEL_W'(sel);
    rd_chk = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    rd_chk = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clear_win_cnt", win_cnt, 0);
    chk("clear_sat_snap", sat_snap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_snap_valid", snap_valid, 0);
    chk("reset_sat_snap", sat_snap, 0);
    chk("reset_win_cnt", win_cnt, 0);

    // windowed basic
    mode = 1'b0;
    pulses(0, 5);
    pulses(3, 2);
    do_tick(1, '0, '0);
    rd(0, 5);
    rd(3, 2);
    rd(1, 0);
    rd(13, 0);

    // edge coincident with tick belongs to the new window
    pulses(1, 3);
    do_tick(2, '0, NCH'(1) << 1);
    rd(1, 3);
    do_tick(3, '0, '0);
    rd(1, 1);

    // cumulative
    do_clear();
    mode = 1'b1;
    pulses(1, 4);
    do_tick(1, '0, '0);
    rd(1, 4);
    pulses(1, 3);
    do_tick(2, '0, '0);
    rd(1, 7);

    // saturation at CNT_W=4
    mode = 1'b0;
    do_clear();
    pulses(2, 17);
    do_tick(1, NCH'(1) << 2, '0);
    rd(2, 15);
    pulses(2, 1);
    do_tick(2, '0, '0);
    rd(2, 1);

    // clear beats tick; edge coincident with clear is dropped and not recounted
    do_clear();
    pulses(0, 6);
    @(negedge clk);
    spike_in[0] = 1'b1;
    clear = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tick  = 1'b0;
    chk("clear_tick_snap_valid", snap_valid, 0);
    chk("clear_tick_win_cnt", win_cnt, 0);
    repeat (3) @(negedge clk);
    spike_in[0] = 1'b0;
    do_tick(1, '0, '0);
    rd(0, 0);

    // read mux range and reset mid-window
    pulses(5, 9);
    do_tick(2, '0, '0);
    rd(5, 9);
    rd(15, 0);
    rd(14, 0);
    rd(5, 9);
    pulses(5, 4);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midreset_rd_data", rd_data, 0);
    chk("midreset_snap_valid", snap_valid, 0);
    chk("midreset_sat_snap", sat_snap, 0);
    chk("midreset_win_cnt", win_cnt, 0);
    do_tick(1, '0, '0);
    rd(5, 0);

    repeat (4) @(negedge clk);
    chk("snap_q_drained", snap_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
